// File: rtl/nios2_oci_trace_pkg.sv
// Shared types and constants for the OCI trace monitor.
// State encoding, saturation limits and the width helper used by the FIFO and the top level.
package nios2_oci_trace_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } trace_state_t;

  localparam logic [31:0] CAPTURE_MAX = '1;
  localparam logic [15:0] LOST_MAX    = '1;

  // Ceiling log2, used to size pointers and the occupancy output.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/nios2_oci_trace_monitor_if.sv
// Trace capture and drain bundle between the packer/drain side (master) and the monitor (slave).
interface nios2_oci_trace_monitor_if #(
  parameter int DCT_W = 30,
  parameter int CNT_W = 4
);
  logic [DCT_W-1:0]       dct_buffer;
  logic [CNT_W-1:0]       dct_count;
  logic                   dct_valid;
  logic                   rd_req;
  logic                   rd_valid;
  logic [DCT_W+CNT_W-1:0] rd_data;

  modport master (
    output dct_buffer, dct_count, dct_valid, rd_req,
    input  rd_valid, rd_data
  );

  modport slave (
    input  dct_buffer, dct_count, dct_valid, rd_req,
    output rd_valid, rd_data
  );
endinterface

// File: rtl/nios2_oci_trace_fifo.sv
// Trace entry FIFO: array storage with registered read, extra-MSB pointers,
// and either drop-newest or overwrite-oldest behaviour when full.
module nios2_oci_trace_fifo
  import nios2_oci_trace_pkg::*;
#(
  parameter int W         = 34,
  parameter int DEPTH     = 16,
  parameter int WRAP_MODE = 0,
  localparam int AW       = clog2(DEPTH),
  localparam int PW       = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          dout_valid,
  output logic [PW-1:0] level,
  output logic          empty,
  output logic          accepted,
  output logic          lost
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PW-1:0] wr_ptr_next, rd_ptr_next;
  logic [W-1:0]  dout_reg;
  logic          dout_valid_reg;
  logic          full, do_pop, do_write, do_drop, do_evict;

  assign level = wr_ptr_reg - rd_ptr_reg;
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop = pop && !empty;

  // A pop in the same cycle always frees a slot, so only a lone push into a full FIFO loses data.
  always_comb begin
    do_write = 1'b0;
    do_drop  = 1'b0;
    do_evict = 1'b0;
    if (push) begin
      if (!full || do_pop) begin
        do_write = 1'b1;
      end else if (WRAP_MODE != 0) begin
        do_write = 1'b1;
        do_evict = 1'b1;
      end else begin
        do_drop = 1'b1;
      end
    end
  end

  assign accepted    = do_write;
  assign lost        = do_drop || do_evict;
  assign wr_ptr_next = wr_ptr_reg + PW'(do_write);
  assign rd_ptr_next = rd_ptr_reg + PW'(do_pop || do_evict);

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr_reg[AW-1:0]] <= din;
    end
  end

  // Read-before-write: a push+pop on the same slot returns the old entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      dout_valid_reg <= do_pop;
      if (do_pop) begin
        dout_reg <= mem[rd_ptr_reg[AW-1:0]];
      end
    end
  end

  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;

endmodule

// File: rtl/nios2_oci_trace_monitor.sv
// OCI trace monitor: captures packer words into a FIFO, counts captures/losses, sequences end-of-test.
// Optional macro NIOS2_OCI_TRACE_DISPLAY_EN enables simulation-only trace and summary printing.
module nios2_oci_trace_monitor
  import nios2_oci_trace_pkg::*;
#(
  parameter int DCT_W     = 30,
  parameter int CNT_W     = 4,
  parameter int DEPTH     = 16,
  parameter int WRAP_MODE = 0,
  localparam int LEVEL_W  = clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  nios2_oci_trace_monitor_if.slave bus,
  input  logic                 test_ending,
  input  logic                 test_has_ended,
  output logic [LEVEL_W-1:0]   fifo_level,
  output logic [31:0]          capture_count,
  output logic [15:0]          lost_count,
  output logic                 overflow,
  output logic                 end_done
);

  trace_state_t       state_reg;
  logic               end_done_reg;
  logic               overflow_reg;
  logic [31:0]        capture_count_reg;
  logic [15:0]        lost_count_reg;
  logic               push, fifo_empty, fifo_accepted, fifo_lost, last_pop;
  logic [LEVEL_W-1:0] level;

  assign push = bus.dct_valid && (bus.dct_count != '0) && (state_reg == RUN);

  nios2_oci_trace_fifo #(
    .W         (DCT_W + CNT_W),
    .DEPTH     (DEPTH),
    .WRAP_MODE (WRAP_MODE)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .pop        (bus.rd_req),
    .din        ({bus.dct_count, bus.dct_buffer}),
    .dout       (bus.rd_data),
    .dout_valid (bus.rd_valid),
    .level      (level),
    .empty      (fifo_empty),
    .accepted   (fifo_accepted),
    .lost       (fifo_lost)
  );

  // FLUSH never pushes, so the FIFO is empty after this cycle if it already is or the last entry is popped.
  assign last_pop = (level == LEVEL_W'(1)) && bus.rd_req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= RUN;
      end_done_reg <= 1'b0;
    end else if (test_has_ended) begin
      state_reg    <= DONE;
      end_done_reg <= 1'b1;
    end else begin
      case (state_reg)
        RUN: begin
          if (test_ending) begin
            state_reg <= FLUSH;
          end
        end
        FLUSH: begin
          if (fifo_empty || last_pop) begin
            state_reg    <= DONE;
            end_done_reg <= 1'b1;
          end
        end
        DONE: begin
          end_done_reg <= 1'b1;
        end
        default: begin
          state_reg    <= RUN;
          end_done_reg <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      capture_count_reg <= '0;
      lost_count_reg    <= '0;
      overflow_reg      <= 1'b0;
    end else begin
      if (fifo_accepted && (capture_count_reg != CAPTURE_MAX)) begin
        capture_count_reg <= capture_count_reg + 32'd1;
      end
      if (fifo_lost) begin
        overflow_reg <= 1'b1;
        if (lost_count_reg != LOST_MAX) begin
          lost_count_reg <= lost_count_reg + 16'd1;
        end
      end
    end
  end

  assign fifo_level    = level;
  assign capture_count = capture_count_reg;
  assign lost_count    = lost_count_reg;
  assign overflow      = overflow_reg;
  assign end_done      = end_done_reg;

`ifdef NIOS2_OCI_TRACE_DISPLAY_EN
  logic summary_shown_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      summary_shown_reg <= 1'b0;
    end else begin
      if (fifo_accepted) begin
        $display("TRACE t=%0t cnt=%0d buf=%h", $time, bus.dct_count, bus.dct_buffer);
      end
      if ((state_reg == DONE) && !summary_shown_reg) begin
        summary_shown_reg <= 1'b1;
        $display("TRACE summary capture_count=%0d lost_count=%0d overflow=%0b",
                 capture_count_reg, lost_count_reg, overflow_reg);
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_nios2_oci_trace_monitor.sv
// Drives a drop-mode and an overwrite-mode monitor with identical stimulus and
// compares both against a queue-based reference model every cycle.
module tb_nios2_oci_trace_monitor;

  localparam int DCT_W = 30;
  localparam int CNT_W = 4;
  localparam int DEPTH = 16;
  localparam int W     = DCT_W + CNT_W;

  typedef logic [W-1:0] word_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_v = 1'b0;
  logic [CNT_W-1:0] in_c = '0;
  logic [DCT_W-1:0] in_b = '0;
  logic in_rd = 1'b0;
  logic in_te = 1'b0;
  logic in_the = 1'b0;

  always #5 clk = ~clk;

  nios2_oci_trace_monitor_if #(.DCT_W(DCT_W), .CNT_W(CNT_W)) bus0 ();
  nios2_oci_trace_monitor_if #(.DCT_W(DCT_W), .CNT_W(CNT_W)) bus1 ();

  assign bus0.dct_valid  = in_v;
  assign bus0.dct_count  = in_c;
  assign bus0.dct_buffer = in_b;
  assign bus0.rd_req     = in_rd;
  assign bus1.dct_valid  = in_v;
  assign bus1.dct_count  = in_c;
  assign bus1.dct_buffer = in_b;
  assign bus1.rd_req     = in_rd;

  logic [4:0]  lvl0, lvl1;
  logic [31:0] cap0, cap1;
  logic [15:0] lost0, lost1;
  logic        ovf0, ovf1, done0, done1;

  nios2_oci_trace_monitor #(.DCT_W(DCT_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .WRAP_MODE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0.slave), .test_ending(in_te), .test_has_ended(in_the),
    .fifo_level(lvl0), .capture_count(cap0), .lost_count(lost0), .overflow(ovf0), .end_done(done0)
  );

  nios2_oci_trace_monitor #(.DCT_W(DCT_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .WRAP_MODE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1.slave), .test_ending(in_te), .test_has_ended(in_the),
    .fifo_level(lvl1), .capture_count(cap1), .lost_count(lost1), .overflow(ovf1), .end_done(done1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model, one slot per wrap mode.
  word_t  mq [2][$];
  longint mcap [2];
  longint mlost [2];
  bit     movf [2];
  bit     mflush [2];
  bit     mended [2];
  bit     exp_rv [2];
  word_t  exp_rd [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mq[m].delete();
      mcap[m] = 0;
      mlost[m] = 0;
      movf[m] = 0;
      mflush[m] = 0;
      mended[m] = 0;
      exp_rv[m] = 0;
      exp_rd[m] = '0;
    end
  endtask

  task automatic model_step(input int m);
    bit push, pop;
    word_t w;
    push = in_v && (in_c != 0) && !mflush[m] && !mended[m];
    pop  = in_rd && (mq[m].size() > 0);
    exp_rv[m] = pop;
    if (pop) exp_rd[m] = mq[m].pop_front();
    if (push) begin
      w = {in_c, in_b};
      if (mq[m].size() < DEPTH) begin
        mq[m].push_back(w);
        mcap[m]++;
      end else begin
        mlost[m]++;
        movf[m] = 1;
        if (m == 1) begin
          void'(mq[m].pop_front());
          mq[m].push_back(w);
          mcap[m]++;
        end
      end
    end
    if (in_the) mended[m] = 1;
    else if (!mflush[m] && !mended[m] && in_te) mflush[m] = 1;
    else if (mflush[m] && !mended[m] && (mq[m].size() == 0)) mended[m] = 1;
  endtask

  task automatic check_dut(input int m, input logic rv, input word_t rd, input logic [4:0] lvl,
                           input logic [31:0] cap, input logic [15:0] lost, input logic ovf, input logic done);
    longint ecap, elost;
    ecap  = (mcap[m] > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : mcap[m];
    elost = (mlost[m] > 64'hFFFF) ? 64'hFFFF : mlost[m];
    chk($sformatf("m%0d rd_valid", m), 64'(rv), 64'(exp_rv[m]));
    chk($sformatf("m%0d rd_data", m), 64'(rd), 64'(exp_rd[m]));
    chk($sformatf("m%0d fifo_level", m), 64'(lvl), 64'(mq[m].size()));
    chk($sformatf("m%0d capture_count", m), 64'(cap), 64'(ecap));
    chk($sformatf("m%0d lost_count", m), 64'(lost), 64'(elost));
    chk($sformatf("m%0d overflow", m), 64'(ovf), 64'(movf[m]));
    chk($sformatf("m%0d end_done", m), 64'(done), 64'(mended[m]));
  endtask

  task automatic check_all();
    check_dut(0, bus0.rd_valid, bus0.rd_data, lvl0, cap0, lost0, ovf0, done0);
    check_dut(1, bus1.rd_valid, bus1.rd_data, lvl1, cap1, lost1, ovf1, done1);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    in_v = 0; in_c = '0; in_b = '0; in_rd = 0; in_te = 0; in_the = 0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    idle_inputs();
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset_n = 1;

    // Five pushes with count 3, then drain in order and one read while empty.
    for (int i = 0; i < 5; i++) begin
      in_v = 1; in_c = 4'd3; in_b = DCT_W'($urandom);
      cycle();
    end
    in_v = 0;
    cycle();
    chk("level after 5 pushes", 64'(lvl0), 64'd5);
    chk("capture after 5 pushes", 64'(cap0), 64'd5);
    for (int i = 0; i < 6; i++) begin
      in_rd = 1;
      cycle();
    end
    chk("read while empty ignored", 64'(bus0.rd_valid), 64'd0);
    in_rd = 0;

    // Valid with a zero count is not a capture.
    in_v = 1; in_c = '0; in_b = DCT_W'($urandom);
    repeat (3) cycle();
    chk("zero count ignored", 64'(cap0), 64'd5);

    // Twenty pushes into a 16-deep FIFO.
    for (int i = 1; i <= 20; i++) begin
      in_v = 1; in_c = CNT_W'($urandom_range(1, 15)); in_b = DCT_W'(i);
      cycle();
    end
    in_v = 0;
    cycle();
    chk("drop mode level", 64'(lvl0), 64'd16);
    chk("drop mode lost", 64'(lost0), 64'd4);
    chk("wrap mode lost", 64'(lost1), 64'd4);
    chk("drop mode capture", 64'(cap0), 64'd21);
    chk("wrap mode capture", 64'(cap1), 64'd25);
    in_rd = 1;
    cycle();
    chk("drop mode oldest word", 64'(bus0.rd_data[DCT_W-1:0]), 64'd1);
    chk("wrap mode oldest word", 64'(bus1.rd_data[DCT_W-1:0]), 64'd5);
    repeat (15) cycle();
    in_rd = 0;

    // Fill, then push and pop together while full.
    for (int i = 0; i < 16; i++) begin
      in_v = 1; in_c = CNT_W'($urandom_range(1, 15)); in_b = DCT_W'($urandom);
      cycle();
    end
    in_rd = 1;
    for (int i = 0; i < 4; i++) begin
      in_b = DCT_W'($urandom);
      cycle();
    end
    chk("full push+pop level", 64'(lvl0), 64'd16);
    chk("full push+pop no loss", 64'(lost0), 64'd4);
    in_v = 0;
    repeat (17) cycle();
    in_rd = 0;

    // Randomised traffic with occasional zero counts and reads.
    for (int i = 0; i < 300; i++) begin
      in_v  = ($urandom_range(0, 3) != 0);
      in_c  = CNT_W'($urandom_range(0, 15));
      in_b  = DCT_W'($urandom);
      in_rd = ($urandom_range(0, 2) == 0);
      cycle();
    end

    // Flush sequencing: three entries, test_ending, pushes ignored, drain to DONE.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_v = 1; in_c = CNT_W'($urandom_range(1, 15)); in_b = DCT_W'($urandom);
      cycle();
    end
    in_v = 0; in_te = 1;
    cycle();
    in_te = 0; in_v = 1; in_c = 4'd2; in_b = DCT_W'($urandom);
    repeat (2) cycle();
    chk("flush blocks pushes", 64'(lvl0), 64'd3);
    in_v = 0; in_rd = 1;
    repeat (2) cycle();
    chk("not done before last pop", 64'(done0), 64'd0);
    cycle();
    chk("done after last pop", 64'(done0), 64'd1);
    in_rd = 0;
    cycle();

    // test_ending and test_has_ended together, drain, then reset mid-drain.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_v = 1; in_c = CNT_W'($urandom_range(1, 15)); in_b = DCT_W'($urandom);
      cycle();
    end
    in_v = 0; in_te = 1; in_the = 1;
    cycle();
    chk("immediate done", 64'(done0), 64'd1);
    in_te = 0; in_the = 0; in_v = 1; in_c = 4'd5;
    cycle();
    in_v = 0; in_rd = 1;
    repeat (3) cycle();
    chk("pending read valid", 64'(bus1.rd_valid), 64'd1);
    do_reset();
    chk("reset squashes rd_valid", 64'(bus0.rd_valid), 64'd0);
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
